// File: rtl/ifft8_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT: load 8 bins, 12 time-shared butterflies, stream 8 samples.
// Build option: define IFFT8_ROUND_EN for round-half-up stage halving (default is floor).
module ifft8_seq #(
  parameter int DW  = 12,
  parameter int C45 = 1448
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data
);

  localparam int CW = 12;
  localparam int SW = DW + 1;
  localparam int PW = SW + CW;
  localparam int TW = DW + 2;
  localparam int VW = DW + 3;

  localparam logic signed [CW-1:0] W_C45  = CW'(C45);
  localparam logic signed [VW-1:0] SAT_HI = VW'((1 << (DW - 1)) - 1);
  localparam logic signed [VW-1:0] SAT_LO = VW'(-(1 << (DW - 1)));

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMP,
    ST_OUT
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [2*DW-1:0]   r_buf [8];
  logic [2:0]        r_cnt;
  logic [1:0]        r_s;
  logic [1:0]        r_b;

  logic [2:0]        w_rev;
  logic [2:0]        w_top;
  logic [2:0]        w_bot;
  logic [1:0]        w_tw;
  logic              w_last_bfly;

  logic signed [DW-1:0] w_ar;
  logic signed [DW-1:0] w_ai;
  logic signed [DW-1:0] w_br;
  logic signed [DW-1:0] w_bi;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_dif;
  logic signed [PW-1:0] w_psum;
  logic signed [PW-1:0] w_pdif;
  logic signed [TW-1:0] w_tr;
  logic signed [TW-1:0] w_ti;
  logic signed [VW-1:0] w_vtr;
  logic signed [VW-1:0] w_vti;
  logic signed [VW-1:0] w_vbr;
  logic signed [VW-1:0] w_vbi;
  logic [2*DW-1:0]      w_top_data;
  logic [2*DW-1:0]      w_bot_data;

  function automatic logic signed [VW-1:0] halve(input logic signed [VW-1:0] v);
`ifdef IFFT8_ROUND_EN
    return (v + VW'(1)) >>> 1;
`else
    return v >>> 1;
`endif
  endfunction

  function automatic logic [DW-1:0] sat(input logic signed [VW-1:0] v);
    logic signed [VW-1:0] c;
    c = v;
    if (v > SAT_HI) c = SAT_HI;
    else if (v < SAT_LO) c = SAT_LO;
    return c[DW-1:0];
  endfunction

  // Samples land bit-reversed so the DIT stages read in place and output is natural order
  assign w_rev       = {r_cnt[0], r_cnt[1], r_cnt[2]};
  assign w_last_bfly = (r_s == 2'd2) && (r_b == 2'd3);

  always_comb begin
    w_top = {r_b, 1'b0};
    w_bot = {r_b, 1'b1};
    w_tw  = 2'd0;
    case (r_s)
      2'd0: begin
        w_top = {r_b, 1'b0};
        w_bot = {r_b, 1'b1};
        w_tw  = 2'd0;
      end
      2'd1: begin
        w_top = {r_b[1], 1'b0, r_b[0]};
        w_bot = {r_b[1], 1'b1, r_b[0]};
        w_tw  = {r_b[0], 1'b0};
      end
      default: begin
        w_top = {1'b0, r_b};
        w_bot = {1'b1, r_b};
        w_tw  = r_b;
      end
    endcase
  end

  assign w_ar = r_buf[w_top][2*DW-1:DW];
  assign w_ai = r_buf[w_top][DW-1:0];
  assign w_br = r_buf[w_bot][2*DW-1:DW];
  assign w_bi = r_buf[w_bot][DW-1:0];

  assign w_sum  = SW'(w_br) + SW'(w_bi);
  assign w_dif  = SW'(w_br) - SW'(w_bi);
  assign w_psum = PW'(w_sum) * PW'(W_C45);
  assign w_pdif = PW'(w_dif) * PW'(W_C45);

  // T = B * exp(+j*pi*t/4); odd twiddles scale by sqrt(2)/2 then shift back out of Q1.11
  always_comb begin
    w_tr = TW'(w_br);
    w_ti = TW'(w_bi);
    case (w_tw)
      2'd1: begin
        w_tr = TW'(w_pdif >>> 11);
        w_ti = TW'(w_psum >>> 11);
      end
      2'd2: begin
        w_tr = -TW'(w_bi);
        w_ti = TW'(w_br);
      end
      2'd3: begin
        w_tr = TW'((-w_psum) >>> 11);
        w_ti = TW'(w_pdif >>> 11);
      end
      default: begin
        w_tr = TW'(w_br);
        w_ti = TW'(w_bi);
      end
    endcase
  end

  assign w_vtr = VW'(w_ar) + VW'(w_tr);
  assign w_vti = VW'(w_ai) + VW'(w_ti);
  assign w_vbr = VW'(w_ar) - VW'(w_tr);
  assign w_vbi = VW'(w_ai) - VW'(w_ti);

  assign w_top_data = {sat(halve(w_vtr)), sat(halve(w_vti))};
  assign w_bot_data = {sat(halve(w_vbr)), sat(halve(w_vbi))};

  always_comb begin
    w_nxt     = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_cnt == 3'd7)) w_nxt = ST_COMP;
      end
      ST_COMP: begin
        if (w_last_bfly) w_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready && (r_cnt == 3'd7)) w_nxt = ST_LOAD;
      end
      default: w_nxt = ST_LOAD;
    endcase
  end

  assign out_data = out_valid ? r_buf[r_cnt] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
      r_s     <= '0;
      r_b     <= '0;
      for (int i = 0; i < 8; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        ST_LOAD: begin
          if (in_valid) begin
            r_buf[w_rev] <= in_data;
            r_cnt        <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_s <= '0;
              r_b <= '0;
            end
          end
        end
        ST_COMP: begin
          r_buf[w_top] <= w_top_data;
          r_buf[w_bot] <= w_bot_data;
          r_b          <= r_b + 2'd1;
          if (w_last_bfly) begin
            r_s   <= '0;
            r_cnt <= '0;
          end else if (r_b == 2'd3) begin
            r_s <= r_s + 2'd1;
          end
        end
        ST_OUT: begin
          if (out_ready) r_cnt <= r_cnt + 3'd1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft8_seq.sv
// Scoreboard bench for ifft8_seq: directed frames push expected outputs, a monitor pops on each output handshake.
module tb_ifft8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;

  logic [23:0] sb[$];
  logic [23:0] m_exp;
  int          n_vec = 0;
  int          n_err = 0;
  int          m_idx = 0;

  ifft8_seq #(.DW(12), .C45(1448)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] cpx(input int re, input int im);
    logic [11:0] r;
    logic [11:0] i;
    r = re[11:0];
    i = im[11:0];
    return {r, i};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every accepted output sample is compared to the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out got=%h expected=none", out_data);
      end else begin
        m_exp = sb.pop_front();
        if (out_data !== m_exp) begin
          n_err++;
          $display("FAIL out_x%0d got=%h expected=%h", m_idx, out_data, m_exp);
        end
        m_idx = (m_idx + 1) % 8;
      end
    end
  end

  task automatic load_frame(input logic [23:0] x[8], input bit gaps);
    int g;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = x[k];
      g = 0;
      while (!in_ready && g < 100) begin
        @(posedge clk); #1;
        g++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      if (gaps && k < 7) begin
        in_valid = 1'b0;
        in_data  = 24'hABCDEF;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    in_data  = 24'h5A5A5A;
  endtask

  task automatic wait_out(input string nm);
    int cyc;
    cyc = 0;
    check({nm, "_in_ready_comp"}, 32'(in_ready), 32'd0);
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_latency"}, 32'(cyc), 32'd12);
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check({nm, "_drained"}, 32'(sb.size()), 32'd0);
    check({nm, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({nm, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_frame(input string nm, input logic [23:0] x[8], input logic [23:0] y[8],
                           input bit gaps);
    for (int i = 0; i < 8; i++) sb.push_back(y[i]);
    load_frame(x, gaps);
    wait_out(nm);
    drain(nm);
  endtask

  logic [23:0] x_imp[8];
  logic [23:0] y_imp[8];
  logic [23:0] x_dc[8];
  logic [23:0] y_dc[8];
  logic [23:0] x_b1[8];
  logic [23:0] y_b1[8];

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      x_imp[i] = (i == 0) ? cpx(256, 0) : cpx(0, 0);
      y_imp[i] = cpx(32, 0);
      x_dc[i]  = cpx(800, 0);
      y_dc[i]  = (i == 0) ? cpx(800, 0) : cpx(0, 0);
      x_b1[i]  = (i == 1) ? cpx(1024, 0) : cpx(0, 0);
    end
    y_b1[0] = cpx(128, 0);
    y_b1[2] = cpx(0, 128);
    y_b1[4] = cpx(-128, 0);
    y_b1[6] = cpx(0, -128);
`ifdef IFFT8_ROUND_EN
    y_b1[1] = cpx(91, 91);
    y_b1[3] = cpx(-90, 91);
    y_b1[5] = cpx(-90, -90);
    y_b1[7] = cpx(91, -90);
`else
    y_b1[1] = cpx(90, 90);
    y_b1[3] = cpx(-91, 90);
    y_b1[5] = cpx(-91, -91);
    y_b1[7] = cpx(90, -91);
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 24'h0;
    out_ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_frame("impulse", x_imp, y_imp, 1'b0);
    run_frame("dc", x_dc, y_dc, 1'b1);
    run_frame("bin1", x_b1, y_b1, 1'b0);

    // Backpressure: stall for 5 cycles while x[3] is presented
    for (int i = 0; i < 8; i++) sb.push_back(y_b1[i]);
    load_frame(x_b1, 1'b0);
    wait_out("bp");
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_data", 32'(out_data), 32'(y_b1[3]));
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    drain("bp");

    // Abort mid-compute; the aborted frame contributes no expected output
    load_frame(x_b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_idx = 0;
    run_frame("post_abort", x_imp, y_imp, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
